// File: rtl/store_data_formatter.sv
// store_data_formatter
//   Store-side byte-lane formatter and write handshake toward data memory.
//   On an accepted start strobe, the register data is formatted into
//   little-endian byte lanes with matching byte enables. The block then
//   holds a write request (MOV) until memory answers with MFC. A doubleword
//   store is issued as two word writes at consecutive word addresses. Each
//   transfer is guarded by an optional MFC timeout.
//
// Ports
//   CLK       in   1   clock, rising edge
//   RST_N     in   1   synchronous active-low reset
//   E         in   1   start strobe, only looked at while idle
//   dataSize  in   2   00 byte, 01 half, 10 word, 11 doubleword
//   ADDR      in   32  byte address of the store
//   D         in   32  store data (low word of a doubleword)
//   D2        in   32  high word of a doubleword
//   MFC       in   1   memory function complete
//   MEM_ADDR  out  32  word-aligned write address
//   MEM_DATA  out  32  lane-replicated write data
//   BE        out  4   byte enables, BE[i] covers MEM_DATA[8i+7:8i]
//   MOV       out  1   write request valid
//   BUSY      out  1   high whenever not idle
//   DONE      out  1   one-cycle pulse after the last transfer completes
//   ERR       out  1   one-cycle pulse on misalignment or timeout
module store_data_formatter #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        E,
    input  logic [1:0]  dataSize,
    input  logic [31:0] ADDR,
    input  logic [31:0] D,
    input  logic [31:0] D2,
    input  logic        MFC,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_DATA,
    output logic [3:0]  BE,
    output logic        MOV,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    // The timer only has to count 0..TIMEOUT-1. The transfer aborts on the
    // edge that would have taken it to TIMEOUT.
    localparam int          TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_XFER0,
        S_XFER1,
        S_FIN,
        S_FAIL
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   timer_q;
    logic [31:0]     hi_q;       // high word, used only by the second dword beat
    logic            dword_q;
    logic [31:0]     addr_q;
    logic [31:0]     data_q;
    logic [3:0]      be_q;
    logic            mov_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;

    // Lane formatting and alignment check, taken straight from the inputs
    // so the first beat can be loaded on the same edge that accepts E.
    logic [31:0] fmt_data_d;
    logic [3:0]  fmt_be_d;
    logic        aligned_d;

    always_comb begin
        fmt_data_d = D;
        fmt_be_d   = 4'b1111;
        aligned_d  = (ADDR[1:0] == 2'b00);
        case (dataSize)
            2'b00: begin
                fmt_data_d = {4{D[7:0]}};
                fmt_be_d   = 4'b0001 << ADDR[1:0];
                aligned_d  = 1'b1;
            end
            2'b01: begin
                fmt_data_d = {2{D[15:0]}};
                fmt_be_d   = ADDR[1] ? 4'b1100 : 4'b0011;
                aligned_d  = ~ADDR[0];
            end
            default: ;  // word and dword keep the full-word defaults
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            hi_q    <= '0;
            dword_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            mov_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // DONE and ERR are single-cycle pulses by default.
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (E) begin
                        hi_q    <= D2;
                        dword_q <= (dataSize == 2'b11);
                        timer_q <= '0;
                        busy_q  <= 1'b1;
                        if (aligned_d) begin
                            state_q <= S_XFER0;
                            mov_q   <= 1'b1;
                            addr_q  <= {ADDR[31:2], 2'b00};
                            data_q  <= fmt_data_d;
                            be_q    <= fmt_be_d;
                        end else begin
                            // A misaligned store never raises MOV.
                            state_q <= S_FAIL;
                            err_q   <= 1'b1;
                        end
                    end
                end

                S_XFER0, S_XFER1: begin
                    // MFC is checked before the limit, so a completion in
                    // the last allowed cycle still counts as success.
                    if (MFC) begin
                        timer_q <= '0;
                        if (state_q == S_XFER0 && dword_q) begin
                            // Second beat: MOV stays high with no bubble.
                            state_q <= S_XFER1;
                            addr_q  <= addr_q + 32'd4;  // wraps at 2^32
                            data_q  <= hi_q;
                            be_q    <= 4'b1111;
                        end else begin
                            state_q <= S_FIN;
                            mov_q   <= 1'b0;
                            be_q    <= '0;
                            done_q  <= 1'b1;
                        end
                    end else if (TIMEOUT > 0 && timer_q == TMAX) begin
                        state_q <= S_FAIL;
                        mov_q   <= 1'b0;
                        be_q    <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end

                S_FIN, S_FAIL: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    mov_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign MEM_ADDR = addr_q;
    assign MEM_DATA = data_q;
    assign BE       = be_q;
    assign MOV      = mov_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;

endmodule
